// File: rtl/stw_pkg.sv
// Shared types and the built-in self-test vector table for the systolic test wrapper scheduler.
package stw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOST  = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    WAIT  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } stw_state_t;

  localparam int TABLE_LEN = 4;

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] add;
    logic [15:0] expected;
  } stw_vec_t;

  // expected = op1*op2 + add, truncated to 16 bits
  localparam stw_vec_t VEC_TABLE [0:TABLE_LEN-1] = '{
    '{op1: 16'h0004, op2: 16'h0003, add: 16'h0000, expected: 16'h000C},
    '{op1: 16'h0007, op2: 16'h0005, add: 16'h0003, expected: 16'h0026},
    '{op1: 16'hFFFF, op2: 16'h0001, add: 16'h0001, expected: 16'h0000},
    '{op1: 16'h0000, op2: 16'h0009, add: 16'h0005, expected: 16'h0005}
  };

  function automatic stw_vec_t vec_at(input int idx);
    if (idx >= 0 && idx < TABLE_LEN) return VEC_TABLE[idx];
    return '0;
  endfunction

endpackage

// File: rtl/stw_period_timer.sv
// Counts idle/host cycles until the next periodic self-test is due; holds once expired.
module stw_period_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en,
  input  logic        clear,
  input  logic [15:0] period,
  output logic        expired
);

  logic [15:0] count;

  // >= rather than == so lowering the period below the running count still fires
  assign expired = (period != 16'd0) && (count >= period);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (count_en && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/stw_scheduler.sv
// Arbitrates the array between the host and periodic/forced self-test passes, and sequences
// each pass through the vector table with timeout and sticky fault reporting.
module stw_scheduler
  import stw_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_VEC   = 4,
  parameter int TMO_CYC   = 255,
  localparam int IDX_W    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_req,
  input  logic                 host_done,
  input  logic [15:0]          test_period,
  input  logic                 force_test,
  input  logic                 fault_clear,
  input  logic                 STW_complete_out,
  input  logic                 STW_fault,
  output logic                 host_grant,
  output logic                 STW_test_load_en,
  output logic                 start,
  output logic [WORD_SIZE-1:0] STW_mult_op1,
  output logic [WORD_SIZE-1:0] STW_mult_op2,
  output logic [WORD_SIZE-1:0] STW_add_op,
  output logic [WORD_SIZE-1:0] STW_expected,
  output logic                 test_busy,
  output logic                 test_done,
  output logic                 fault_flag,
  output logic                 fault_timeout,
  output logic [IDX_W-1:0]     fault_vec_idx
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  stw_state_t           state, state_n;
  logic [IDX_W-1:0]     vec_idx, vec_idx_n;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_n;
  logic                 test_pending, test_pending_n;
  logic                 fault_cap, fault_cap_n;
  logic                 period_expired;
  logic                 host_grant_n, load_en_n, start_n, test_busy_n, test_done_n;
  logic                 fault_flag_n, fault_timeout_n;
  logic [IDX_W-1:0]     fault_vec_idx_n;
  logic [WORD_SIZE-1:0] op1_n, op2_n, add_n, expected_n;
  stw_vec_t             vec_sel;

  stw_period_timer u_period_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en ((state == IDLE) || (state == HOST)),
    .clear    (state == DONE),
    .period   (test_period),
    .expired  (period_expired)
  );

  // Next-state logic; registered outputs are then derived from the state being entered.
  always_comb begin
    state_n         = state;
    vec_idx_n       = vec_idx;
    tmo_cnt_n       = tmo_cnt;
    test_pending_n  = test_pending;
    fault_cap_n     = fault_cap;
    fault_flag_n    = fault_clear ? 1'b0 : fault_flag;
    fault_timeout_n = fault_clear ? 1'b0 : fault_timeout;
    fault_vec_idx_n = fault_vec_idx;
    op1_n           = STW_mult_op1;
    op2_n           = STW_mult_op2;
    add_n           = STW_add_op;
    expected_n      = STW_expected;
    vec_sel         = '0;

    if (((state == IDLE) || (state == HOST)) && (period_expired || force_test))
      test_pending_n = 1'b1;

    case (state)
      IDLE: begin
        if (test_pending || force_test) begin
          state_n   = LOAD;
          vec_idx_n = '0;
        end else if (host_req) begin
          state_n = HOST;
        end
      end
      HOST: if (host_done) state_n = IDLE;
      LOAD: begin
        state_n   = RUN;
        tmo_cnt_n = '0;
      end
      RUN: begin
        state_n   = WAIT;
        tmo_cnt_n = '0;
      end
      WAIT: begin
        if (STW_complete_out) begin
          fault_cap_n = STW_fault;
          state_n     = CHECK;
        end else if (tmo_cnt == TMO_LAST) begin
          fault_flag_n    = 1'b1;
          fault_timeout_n = 1'b1;
          fault_vec_idx_n = vec_idx;
          state_n         = DONE;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end
      CHECK: begin
        if (fault_cap) begin
          fault_flag_n    = 1'b1;
          fault_vec_idx_n = vec_idx;
          state_n         = DONE;
        end else if (vec_idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          vec_idx_n = vec_idx + IDX_W'(1);
          state_n   = LOAD;
        end
      end
      DONE: begin
        test_pending_n = 1'b0;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase

    host_grant_n = (state_n == HOST);
    load_en_n    = (state_n == LOAD);
    start_n      = (state_n == RUN);
    test_done_n  = (state_n == DONE);
    test_busy_n  = (state_n == LOAD) || (state_n == RUN) || (state_n == WAIT) ||
                   (state_n == CHECK) || (state_n == DONE);

    if (state_n == LOAD) begin
      vec_sel    = vec_at(int'(vec_idx_n));
      op1_n      = WORD_SIZE'(vec_sel.op1);
      op2_n      = WORD_SIZE'(vec_sel.op2);
      add_n      = WORD_SIZE'(vec_sel.add);
      expected_n = WORD_SIZE'(vec_sel.expected);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      vec_idx          <= '0;
      tmo_cnt          <= '0;
      test_pending     <= 1'b0;
      fault_cap        <= 1'b0;
      host_grant       <= 1'b0;
      STW_test_load_en <= 1'b0;
      start            <= 1'b0;
      STW_mult_op1     <= '0;
      STW_mult_op2     <= '0;
      STW_add_op       <= '0;
      STW_expected     <= '0;
      test_busy        <= 1'b0;
      test_done        <= 1'b0;
      fault_flag       <= 1'b0;
      fault_timeout    <= 1'b0;
      fault_vec_idx    <= '0;
    end else begin
      state            <= state_n;
      vec_idx          <= vec_idx_n;
      tmo_cnt          <= tmo_cnt_n;
      test_pending     <= test_pending_n;
      fault_cap        <= fault_cap_n;
      host_grant       <= host_grant_n;
      STW_test_load_en <= load_en_n;
      start            <= start_n;
      STW_mult_op1     <= op1_n;
      STW_mult_op2     <= op2_n;
      STW_add_op       <= add_n;
      STW_expected     <= expected_n;
      test_busy        <= test_busy_n;
      test_done        <= test_done_n;
      fault_flag       <= fault_flag_n;
      fault_timeout    <= fault_timeout_n;
      fault_vec_idx    <= fault_vec_idx_n;
    end
  end

endmodule

// File: tb/tb_stw_scheduler.sv
// Directed bench for stw_scheduler: a scoreboard of expected vector loads plus a model of the
// array that answers each start a fixed number of cycles later.
module tb_stw_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_req = 1'b0;
  logic        host_done = 1'b0;
  logic [15:0] test_period = 16'd0;
  logic        force_test = 1'b0;
  logic        fault_clear = 1'b0;
  logic        STW_complete_out = 1'b0;
  logic        STW_fault = 1'b0;
  logic        host_grant, STW_test_load_en, start;
  logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
  logic        test_busy, test_done, fault_flag, fault_timeout;
  logic [1:0]  fault_vec_idx;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [63:0] sb [$];
  int load_cnt = 0, start_cnt = 0, done_cnt = 0;
  int cyc = 0, start_cycle = 0, done_cycle = 0;
  int cur_vec = 0, resp_cnt = 0;
  int fault_vec = -1;
  bit no_respond = 1'b0;
  bit prev_load = 1'b0;
  bit grant_busy_seen = 1'b0;

  logic [15:0] tb_op1 [4] = '{16'd4, 16'd7, 16'hFFFF, 16'd0};
  logic [15:0] tb_op2 [4] = '{16'd3, 16'd5, 16'd1, 16'd9};
  logic [15:0] tb_add [4] = '{16'd0, 16'd3, 16'd1, 16'd5};

  stw_scheduler #(.WORD_SIZE(16), .NUM_VEC(4), .TMO_CYC(255)) dut (
    .clk              (clk),
    .rst              (rst),
    .host_req         (host_req),
    .host_done        (host_done),
    .test_period      (test_period),
    .force_test       (force_test),
    .fault_clear      (fault_clear),
    .STW_complete_out (STW_complete_out),
    .STW_fault        (STW_fault),
    .host_grant       (host_grant),
    .STW_test_load_en (STW_test_load_en),
    .start            (start),
    .STW_mult_op1     (STW_mult_op1),
    .STW_mult_op2     (STW_mult_op2),
    .STW_add_op       (STW_add_op),
    .STW_expected     (STW_expected),
    .test_busy        (test_busy),
    .test_done        (test_done),
    .fault_flag       (fault_flag),
    .fault_timeout    (fault_timeout),
    .fault_vec_idx    (fault_vec_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic frc, input logic hreq, input logic hdone, input logic fclr);
    force_test  = frc;
    host_req    = hreq;
    host_done   = hdone;
    fault_clear = fclr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected value derived from the bench's own operand arrays
  task automatic pushVec(input int i);
    logic [15:0] e;
    e = 16'(tb_op1[i] * tb_op2[i] + tb_add[i]);
    sb.push_back({tb_op1[i], tb_op2[i], tb_add[i], e});
  endtask

  task automatic waitDone(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (test_done) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(tag, 96'(ok), 96'd1);
  endtask

  task automatic clearCounts();
    load_cnt = 0;
    start_cnt = 0;
    done_cnt = 0;
    grant_busy_seen = 1'b0;
  endtask

  // Monitor, scoreboard pop and array responder share one process to keep ordering fixed.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      resp_cnt = 0;
      cur_vec = 0;
      prev_load = 1'b0;
      STW_complete_out = 1'b0;
      STW_fault = 1'b0;
    end else begin
      STW_complete_out = 1'b0;
      STW_fault = 1'b0;
      if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          STW_complete_out = 1'b1;
          STW_fault = ((cur_vec - 1) == fault_vec);
        end
      end
      if (start) begin
        start_cnt++;
        start_cycle = cyc;
        checkOutput("start_after_load", 96'(prev_load), 96'd1);
        if (!no_respond) resp_cnt = 3;
      end
      if (STW_test_load_en) begin
        load_cnt++;
        cur_vec++;
        checkOutput("load_expected", 96'(sb.size() != 0), 96'd1);
        if (sb.size() != 0)
          checkOutput("load_vector", {32'd0, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected},
                      {32'd0, sb.pop_front()});
      end
      if (test_done) begin
        done_cnt++;
        done_cycle = cyc;
        cur_vec = 0;
      end
      if (host_grant && test_busy) grant_busy_seen = 1'b1;
      prev_load = STW_test_load_en;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    checkOutput("reset_outputs",
                96'({host_grant, STW_test_load_en, start, STW_mult_op1, STW_mult_op2, STW_add_op,
                     STW_expected, test_busy, test_done, fault_flag, fault_timeout, fault_vec_idx}),
                96'd0);
    rst = 1'b1;
    tick(1);
    checkOutput("post_reset_quiet", 96'({STW_test_load_en, start}), 96'd0);

    // Forced full pass, no faults
    $display("[TB] forced pass, all vectors clean");
    clearCounts();
    for (int i = 0; i < 4; i++) pushVec(i);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(200, "pass1_done");
    tick(5);
    checkOutput("pass1_loads", 96'(load_cnt), 96'd4);
    checkOutput("pass1_starts", 96'(start_cnt), 96'd4);
    checkOutput("pass1_done_pulses", 96'(done_cnt), 96'd1);
    checkOutput("pass1_fault", 96'({fault_flag, fault_timeout}), 96'd0);
    checkOutput("pass1_sb_empty", 96'(sb.size()), 96'd0);

    // Fault reported on vector 2 stops the pass
    $display("[TB] fault on vector 2");
    clearCounts();
    fault_vec = 2;
    for (int i = 0; i < 3; i++) pushVec(i);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(200, "pass2_done");
    tick(5);
    fault_vec = -1;
    checkOutput("pass2_loads", 96'(load_cnt), 96'd3);
    checkOutput("pass2_fault_flag", 96'({fault_flag, fault_timeout}), 96'b10);
    checkOutput("pass2_fault_idx", 96'(fault_vec_idx), 96'd2);
    checkOutput("pass2_sb_empty", 96'(sb.size()), 96'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pass2_fault_cleared", 96'(fault_flag), 96'd0);

    // Host and test requested together: test wins, host waits
    $display("[TB] simultaneous host request and force");
    clearCounts();
    for (int i = 0; i < 4; i++) pushVec(i);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("arb_test_first", 96'({STW_test_load_en, host_grant}), 96'b10);
    waitDone(200, "arb_done");
    checkOutput("arb_no_grant_in_test", 96'(grant_busy_seen), 96'd0);
    tick(2);
    checkOutput("arb_grant_after", 96'(host_grant), 96'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("arb_grant_release", 96'(host_grant), 96'd0);
    tick(2);
    checkOutput("arb_loads", 96'(load_cnt), 96'd4);

    // Periodic test becomes due while the host holds the array
    $display("[TB] periodic test deferred behind host");
    rst = 1'b0;
    test_period = 16'd10;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    rst = 1'b1;
    clearCounts();
    for (int i = 0; i < 4; i++) pushVec(i);
    tick(30);
    checkOutput("period_host_held", 96'({host_grant, test_busy}), 96'b10);
    checkOutput("period_no_test_in_host", 96'(load_cnt), 96'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("period_idle_gap", 96'({host_grant, STW_test_load_en}), 96'd0);
    tick(1);
    checkOutput("period_test_start", 96'(STW_test_load_en), 96'd1);
    waitDone(200, "period_done");
    test_period = 16'd0;
    tick(5);
    checkOutput("period_loads", 96'(load_cnt), 96'd4);

    // Array never completes: timeout after 255 WAIT cycles
    $display("[TB] completion timeout");
    clearCounts();
    no_respond = 1'b1;
    pushVec(0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(400, "tmo_done");
    tick(2);
    checkOutput("tmo_flags", 96'({fault_flag, fault_timeout}), 96'b11);
    checkOutput("tmo_idx", 96'(fault_vec_idx), 96'd0);
    checkOutput("tmo_latency", 96'(done_cycle - start_cycle), 96'd256);
    checkOutput("tmo_loads", 96'(load_cnt), 96'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_cleared", 96'({fault_flag, fault_timeout}), 96'd0);

    // Reset in the middle of WAIT, then a clean restart from vector 0
    $display("[TB] reset during WAIT");
    pushVec(0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (start) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput("rstmid_start_seen", 96'(seen), 96'd1);
    end
    tick(5);
    checkOutput("rstmid_busy", 96'(test_busy), 96'd1);
    rst = 1'b0;
    tick(1);
    checkOutput("rstmid_outputs",
                96'({host_grant, STW_test_load_en, start, STW_mult_op1, STW_mult_op2, STW_add_op,
                     STW_expected, test_busy, test_done, fault_flag, fault_timeout, fault_vec_idx}),
                96'd0);
    tick(1);
    rst = 1'b1;
    no_respond = 1'b0;
    tick(2);
    clearCounts();
    for (int i = 0; i < 4; i++) pushVec(i);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(200, "restart_done");
    tick(5);
    checkOutput("restart_loads", 96'(load_cnt), 96'd4);
    checkOutput("restart_done_pulses", 96'(done_cnt), 96'd1);
    checkOutput("restart_fault", 96'({fault_flag, fault_timeout}), 96'd0);
    checkOutput("restart_sb_empty", 96'(sb.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
